// File: rtl/bus_deserializer_pkg.sv
// Shared beat/field definitions for the byte bus (deserializer and arbiter side).
// Holds beat geometry, byte-index names and command-word field helpers.
// No logic, so it adds no latency and has no flow control of its own.
package bus_deserializer_pkg;

    localparam int BEATS      = 4;
    localparam int BEAT_W     = 8;
    localparam int CMD_ADDR_W = 24;
    localparam int CMD_W      = CMD_ADDR_W + BEAT_W;

    // Beat index names; beat B0 carries the least significant byte.
    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    // Tag lives in the last beat, i.e. the top byte of the word.
    function automatic logic [BEAT_W-1:0] cmd_tag_f(input logic [CMD_W-1:0] w);
        return w[CMD_W-1:CMD_ADDR_W];
    endfunction

    // Address occupies the first three beats.
    function automatic logic [CMD_ADDR_W-1:0] cmd_addr_f(input logic [CMD_W-1:0] w);
        return w[CMD_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/bus_idle_timer.sv
// Saturating idle counter that fires a one-cycle expire when it reaches LIMIT-1 while enabled.
// Expire is combinational from the count and enable; the count itself is registered.
// No flow control: the caller decides when to count (en_i) and when to restart (clr_i).
module bus_idle_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

    // Count idle cycles, holding at LAST; restart on clear or once the timeout has fired.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i || expire_o) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/bus_deserializer.sv
// Gathers four LSB-first bytes into a {tag, addr} command word and offers it on valid/ready.
// Latency: word appears in the output register one cycle after its last beat is accepted.
// Backpressure: only the last beat stalls, and only while the output is full and not draining.
module bus_deserializer
    import bus_deserializer_pkg::*;
#(
    parameter int ADDRW        = 24,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [ADDRW+7:0]   cmd_out,
    output logic [ADDRW-1:0]   cmd_addr,
    output logic [7:0]         cmd_tag,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               frame_err,
    output logic [1:0]         byte_cnt_top
);

    localparam int W = ADDRW + 8;

    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [ADDRW-1:0] asm_q, asm_d;
    logic [W-1:0]     cmd_q, cmd_d;
    logic             cmd_vld_q, cmd_vld_d;
    logic             frame_err_q, frame_err_d;

    logic beat_acc;
    logic out_drain;
    logic idle_clr;
    logic idle_en;
    logic idle_expire;

    // Ready is forced high in reset so the sender never sees a stale stall.
    assign ready_out = rst || (byte_cnt_q != B3) || !cmd_vld_q || cmd_ready;
    assign beat_acc  = valid_in && ready_out;
    assign out_drain = cmd_vld_q && cmd_ready;

    // Stalled last beats (valid but not ready) neither clear nor advance the idle count.
    assign idle_clr = beat_acc || (byte_cnt_q == B0);
    assign idle_en  = (byte_cnt_q != B0) && !valid_in;

    bus_idle_timer #(
        .LIMIT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (idle_clr),
        .en_i     (idle_en),
        .expire_o (idle_expire)
    );

    // Next-state for beat counter, assembly bytes, output word and the frame error pulse.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        cmd_d       = cmd_q;
        cmd_vld_d   = cmd_vld_q;
        frame_err_d = 1'b0;

        if (out_drain) begin
            cmd_vld_d = 1'b0;
        end

        if (beat_acc) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                B0:      asm_d[7:0]   = data_in;
                B1:      asm_d[15:8]  = data_in;
                B2:      asm_d[23:16] = data_in;
                default: begin
                    // Last beat: a simultaneous drain is overridden, so the new word follows with no bubble.
                    cmd_d     = {data_in, asm_q};
                    cmd_vld_d = 1'b1;
                end
            endcase
        end else if (idle_expire) begin
            byte_cnt_d  = B0;
            asm_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q  <= B0;
            asm_q       <= '0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cmd_out      = cmd_q;
    assign cmd_addr     = cmd_q[ADDRW-1:0];
    assign cmd_tag      = cmd_q[W-1:ADDRW];
    assign cmd_valid    = cmd_vld_q;
    assign frame_err    = frame_err_q;
    assign byte_cnt_top = byte_cnt_q;

endmodule

// File: tb/tb_bus_deserializer.sv
// Bench for bus_deserializer: behavioural byte-queue model checked every cycle plus directed literals.
// Drives inputs 1ns after the rising edge and samples everything on the falling edge.
// Drained words are collected and compared against the words the stimulus intended to send.
module tb_bus_deserializer;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] cmd_out;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_tag;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        frame_err;
    logic [1:0]  byte_cnt_top;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] got_q[$];
    logic [31:0] sent_q[$];
    int stall_cnt = 0;
    int fe_cnt = 0;

    // Behavioural model: bytes collected so far, output slot, idle cycles, expected error pulse.
    logic [7:0]  m_bytes[$];
    bit          m_full = 1'b0;
    logic [31:0] m_word = '0;
    int          m_idle = 0;
    bit          m_ferr = 1'b0;

    bus_deserializer #(
        .ADDRW        (24),
        .IDLE_TIMEOUT (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .cmd_out      (cmd_out),
        .cmd_addr     (cmd_addr),
        .cmd_tag      (cmd_tag),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .frame_err    (frame_err),
        .byte_cnt_top (byte_cnt_top)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin : mon
        bit exp_rdy;
        bit acc;
        bit drn;
        bit nwv;
        bit nf;
        logic [31:0] nw;
        int n;
        n = m_bytes.size();
        exp_rdy = rst || (n != 3) || !m_full || cmd_ready;
        if (chk_en) begin
            chk("ready_out", 32'(ready_out), 32'(exp_rdy));
            chk("cmd_valid", 32'(cmd_valid), 32'(m_full));
            if (m_full) begin
                chk("cmd_out", cmd_out, m_word);
                chk("cmd_tag", 32'(cmd_tag), 32'(m_word[31:24]));
                chk("cmd_addr", 32'(cmd_addr), 32'(m_word[23:0]));
            end
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("byte_cnt", 32'(byte_cnt_top), n);
        end
        if (!rst && valid_in && !ready_out) stall_cnt++;
        if (!rst && frame_err) fe_cnt++;

        if (rst) begin
            m_bytes.delete();
            m_full = 1'b0;
            m_word = '0;
            m_idle = 0;
            m_ferr = 1'b0;
        end else begin
            acc = valid_in && exp_rdy;
            drn = m_full && cmd_ready;
            nwv = 1'b0;
            nf  = 1'b0;
            nw  = '0;
            if (drn) got_q.push_back(cmd_out);
            if (acc) begin
                m_bytes.push_back(data_in);
                m_idle = 0;
                if (m_bytes.size() == 4) begin
                    nw  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    nwv = 1'b1;
                    m_bytes.delete();
                end
            end else if (n != 0 && !valid_in) begin
                m_idle++;
                if (m_idle == T) begin
                    m_bytes.delete();
                    m_idle = 0;
                    nf = 1'b1;
                end
            end else if (n == 0) begin
                m_idle = 0;
            end
            if (nwv) begin
                m_full = 1'b1;
                m_word = nw;
            end else if (drn) begin
                m_full = 1'b0;
            end
            m_ferr = nf;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        valid_in = 1'b1;
        data_in  = b;
        @(negedge clk);
        while (!ready_out && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!ready_out) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte 0x%02h never accepted", b);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic idle(input int g);
        valid_in = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "time limit");
    end

    initial begin : main
        int st0;
        int n0;
        int fe0;
        bit done;
        logic [31:0] w;

        rst = 1'b1; valid_in = 1'b0; data_in = 8'h00; cmd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_out", cmd_out, 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_byte_cnt", 32'(byte_cnt_top), 32'd0);
        @(posedge clk); #1;

        // Single word: one-cycle valid window right after the last beat.
        send_word(32'hA533_2211);
        @(negedge clk);
        chk("single_valid", 32'(cmd_valid), 32'd1);
        chk("single_word", cmd_out, 32'hA533_2211);
        chk("single_tag", 32'(cmd_tag), 32'h0000_00A5);
        chk("single_addr", 32'(cmd_addr), 32'h0033_2211);
        @(negedge clk);
        chk("single_valid_drop", 32'(cmd_valid), 32'd0);
        chk("single_got", got_q[$], 32'hA533_2211);
        @(posedge clk); #1;

        // Back-to-back: eight beats with valid held, never stalled.
        st0 = stall_cnt;
        n0  = got_q.size();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i));
        repeat (3) @(negedge clk);
        chk("b2b_count", got_q.size() - n0, 32'd2);
        chk("b2b_word0", got_q[n0], 32'h1312_1110);
        chk("b2b_word1", got_q[n0+1], 32'h1716_1514);
        chk("b2b_stalls", stall_cnt - st0, 32'd0);
        @(posedge clk); #1;

        // Backpressure: the last beat of word 2 stalls until the output drains.
        cmd_ready = 1'b0;
        send_word(32'h0403_0201);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
        st0 = stall_cnt;
        valid_in = 1'b1; data_in = 8'h08;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(ready_out), 32'd0);
            chk("bp_word_stable", cmd_out, 32'h0403_0201);
        end
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_high", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("bp_word2", cmd_out, 32'h0807_0605);
        chk("bp_valid2", 32'(cmd_valid), 32'd1);
        chk("bp_got1", got_q[$], 32'h0403_0201);
        chk("bp_stalls", stall_cnt - st0, 32'd3);
        @(negedge clk);
        chk("bp_drained", 32'(cmd_valid), 32'd0);
        @(posedge clk); #1;

        // Timeout: two beats then silence; error on the cycle after the T-th idle edge.
        send_byte(8'h77); send_byte(8'h88);
        for (int k = 0; k < T; k++) begin
            @(negedge clk);
            chk("to_early", 32'(frame_err), 32'd0);
        end
        @(negedge clk);
        chk("to_pulse", 32'(frame_err), 32'd1);
        chk("to_cnt", 32'(byte_cnt_top), 32'd0);
        @(negedge clk);
        chk("to_pulse_end", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        repeat (2) @(negedge clk);
        chk("to_resync", got_q[$], 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset with a full output and three beats pending (last beat would otherwise stall).
        cmd_ready = 1'b0;
        send_word(32'h0C0B_0A09);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        n0 = got_q.size();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(cmd_valid), 32'd0);
        chk("rst_mid_out", cmd_out, 32'd0);
        chk("rst_mid_cnt", 32'(byte_cnt_top), 32'd0);
        chk("rst_mid_ferr", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        send_word(32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        chk("rst_after_count", got_q.size() - n0, 32'd1);
        chk("rst_after_word", got_q[$], 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Random gaps and backpressure, 1000 words.
        got_q.delete();
        fe0 = fe_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    w = $urandom;
                    sent_q.push_back(w);
                    for (int b = 0; b < 4; b++) begin
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
                        send_byte(w[8*b +: 8]);
                    end
                end
                valid_in = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    cmd_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        cmd_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_count", got_q.size(), sent_q.size());
        for (int i = 0; i < sent_q.size(); i++) begin
            if (i < got_q.size()) chk("rand_word", got_q[i], sent_q[i]);
        end
        chk("rand_no_ferr", fe_cnt - fe0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
